// File: rtl/stap_link_ctrl.sv
// Attach/detach sequencer for one of N secondary TAPs behind the SiP STAP gating stage.
// Tracks the primary 1149.1 TAP and only changes the gating config while the primary sits in Run-Test/Idle.
module stap_link_ctrl #(
   parameter int N_STAP     = 4,
   parameter int RST_CYCLES = 5,
   parameter int TIMEOUT    = 1024
) (
   input  logic       TCK,
   input  logic       TRST_N,
   input  logic       TMS,
   input  logic       req_valid,
   input  logic       req_attach,
   input  logic [2:0] req_idx,
   output logic       req_ready,
   output logic [7:0] config_reg,
   output logic       stap_rst_n,
   output logic [3:0] tap_state,
   output logic       attached,
   output logic       done,
   output logic       err
);

   typedef enum logic [3:0] {
      TLR    = 4'hF, RTI    = 4'hC,
      SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
      PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
      SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
      PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
   } tap_t;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_SAFE, S_RST, S_SYNC, S_ATTACHED, S_DET_WAIT
   } ctrl_t;

   tap_t        tap_q, tap_d;
   ctrl_t       st_q, st_d;
   logic [15:0] to_q, to_d;
   logic [7:0]  rc_q, rc_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  cfg_d;
   logic        srst_d, att_d, done_d, err_d;
   logic        safe, accept, idx_ok, timeout_hit, rst_last;

   assign tap_state   = tap_q;
   assign req_ready   = (st_q == S_IDLE) || (st_q == S_ATTACHED);
   assign accept      = req_valid && req_ready;
   assign idx_ok      = {1'b0, req_idx} < 4'(N_STAP);
   // The primary stays in RTI across the coming edge, so the secondary joins/leaves between scans.
   assign safe        = (tap_q == RTI) && !TMS;
   assign timeout_hit = (to_q == 16'(TIMEOUT - 1));
   assign rst_last    = (rc_q == 8'(RST_CYCLES - 1));

   always_comb begin
      unique case (tap_q)
         TLR:     tap_d = TMS ? TLR    : RTI;
         RTI:     tap_d = TMS ? SEL_DR : RTI;
         SEL_DR:  tap_d = TMS ? SEL_IR : CAP_DR;
         CAP_DR:  tap_d = TMS ? EX1_DR : SH_DR;
         SH_DR:   tap_d = TMS ? EX1_DR : SH_DR;
         EX1_DR:  tap_d = TMS ? UPD_DR : PAU_DR;
         PAU_DR:  tap_d = TMS ? EX2_DR : PAU_DR;
         EX2_DR:  tap_d = TMS ? UPD_DR : SH_DR;
         UPD_DR:  tap_d = TMS ? SEL_DR : RTI;
         SEL_IR:  tap_d = TMS ? TLR    : CAP_IR;
         CAP_IR:  tap_d = TMS ? EX1_IR : SH_IR;
         SH_IR:   tap_d = TMS ? EX1_IR : SH_IR;
         EX1_IR:  tap_d = TMS ? UPD_IR : PAU_IR;
         PAU_IR:  tap_d = TMS ? EX2_IR : PAU_IR;
         EX2_IR:  tap_d = TMS ? UPD_IR : SH_IR;
         UPD_IR:  tap_d = TMS ? SEL_DR : RTI;
         default: tap_d = TLR;
      endcase
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      st_d   = st_q;
      idx_d  = idx_q;
      cfg_d  = config_reg;
      srst_d = stap_rst_n;
      att_d  = attached;
      done_d = 1'b0;
      err_d  = 1'b0;
      rc_d   = rc_q;
      to_d   = (to_q < 16'(TIMEOUT)) ? to_q + 16'd1 : to_q;
      unique case (st_q)
         S_IDLE: begin
            if (accept) begin
               if (!req_attach) begin
                  done_d = 1'b1;
               end else if (idx_ok) begin
                  st_d  = S_WAIT_SAFE;
                  idx_d = req_idx;
                  to_d  = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_WAIT_SAFE: begin
            if (safe) begin
               st_d   = S_RST;
               cfg_d  = {4'h0, idx_q, 1'b1};
               srst_d = 1'b0;
               rc_d   = '0;
            end else if (timeout_hit) begin
               st_d  = S_IDLE;
               err_d = 1'b1;
            end
         end
         S_RST: begin
            if (rst_last) begin
               st_d   = S_SYNC;
               srst_d = 1'b1;
            end else begin
               rc_d = rc_q + 8'd1;
            end
         end
         S_SYNC: begin
            if (safe) begin
               st_d   = S_ATTACHED;
               att_d  = 1'b1;
               done_d = 1'b1;
            end else if (tap_q != RTI) begin
               // Primary moved before the secondary could follow in lock-step: reset it again.
               st_d   = S_RST;
               srst_d = 1'b0;
               rc_d   = '0;
            end
         end
         S_ATTACHED: begin
            if (accept) begin
               if (req_attach) begin
                  err_d = 1'b1;
               end else begin
                  st_d = S_DET_WAIT;
                  to_d = '0;
               end
            end
         end
         S_DET_WAIT: begin
            if (safe) begin
               st_d   = S_IDLE;
               cfg_d  = 8'h00;
               att_d  = 1'b0;
               done_d = 1'b1;
            end else if (timeout_hit) begin
               st_d  = S_ATTACHED;
               err_d = 1'b1;
            end
         end
         default: st_d = S_IDLE;
      endcase
   end

   // NOTE: TRST_N is sampled on TCK (synchronous reset); all state uses non-blocking assignments.
   always_ff @(posedge TCK) begin
      if (!TRST_N) begin
         tap_q      <= TLR;
         st_q       <= S_IDLE;
         to_q       <= '0;
         rc_q       <= '0;
         idx_q      <= '0;
         config_reg <= 8'h00;
         stap_rst_n <= 1'b1;
         attached   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         tap_q      <= tap_d;
         st_q       <= st_d;
         to_q       <= to_d;
         rc_q       <= rc_d;
         idx_q      <= idx_d;
         config_reg <= cfg_d;
         stap_rst_n <= srst_d;
         attached   <= att_d;
         done       <= done_d;
         err        <= err_d;
      end
   end

endmodule
